move_executor: RTL and testbench
================================

// Module: move_executor
// PURPOSE
//  Consumes one cube move from the sequencer (next_move/start_move) and drives the
//  six face stepper drivers: direction setup, a fixed train of step pulses, then a
//  mechanical settle delay. Signals completion back to the sequencer with a
//  one-cycle move_done pulse. Exactly one motor moves at a time.
// PARAMETERS
//  STEPS_PER_MOVE   50      step pulses per quarter turn (200-step motor, 90 deg)
//  STEP_HALF_CYCLES 50000   clock cycles per step-high and per step-low phase
//  DIR_SETUP_CYCLES 1000    cycles dir is stable before the first step edge
//  SETTLE_CYCLES    100000  cycles of wait after the last step before move_done
// PORTS
//  clock       in   1  system clock
//  reset_n     in   1  asynchronous active-low reset
//  next_move   in   4  [2:0] face 0..5 = U,D,F,B,L,R; [3] 0=CW, 1=CCW
//  start_move  in   1  request: sampled only in IDLE
//  move_done   out  1  one-cycle completion pulse
//  move_err    out  1  high with move_done when face code was 6 or 7
//  busy        out  1  high from acceptance cycle+1 through the move_done cycle
//  step        out  6  step pulse, one bit per face motor
//  dir         out  6  direction level per face motor (1 = CCW)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, all counters 0; move_done=0, move_err=0,
//   busy=0, step=0, dir=0. Reset mid-move drops step immediately; no move_done.
//  States: IDLE, SETUP, STEP_HI, STEP_LO, SETTLE, DONE.
//  IDLE: start_move=1 at cycle 0 -> latch face=next_move[2:0], ccw=next_move[3].
//   Valid face: cycle 1 enter SETUP, dir[face] <= ccw; other dir bits hold.
//   Invalid face (6/7): cycle 1 enter DONE with move_err=1; step/dir untouched.
//  SETUP: DIR_SETUP_CYCLES cycles, then STEP_HI.
//  STEP_HI: step[face]=1 for STEP_HALF_CYCLES cycles, then STEP_LO.
//  STEP_LO: step=0 for STEP_HALF_CYCLES cycles; pulse counter +1; if counter ==
//   STEPS_PER_MOVE -> SETTLE, else STEP_HI.
//  SETTLE: SETTLE_CYCLES cycles, step=0, then DONE.
//  DONE: move_done=1 (move_err as latched) for exactly one cycle, busy=1; next IDLE.
//  Latency (valid face): move_done at cycle
//   1 + DIR_SETUP_CYCLES + 2*STEP_HALF_CYCLES*STEPS_PER_MOVE + SETTLE_CYCLES.
//  start_move while busy (incl. DONE cycle) is ignored, not queued. start_move held
//   high continuously re-triggers on the first IDLE cycle after DONE.
//  next_move is sampled only at acceptance; later changes do not affect the move.
//  step is one-hot or zero at all times; only bit [face] ever toggles.
//  All outputs registered. Counters sized $clog2(param+1); a parameter of 0 for
//   DIR_SETUP/SETTLE means that state lasts 1 cycle.
//  move_err clears on the next accepted move's acceptance.
// TESTING  (bench params: STEPS=3, HALF=2, SETUP=2, SETTLE=4)
//  Reset, idle 10 cycles -> all outputs 0, busy 0.
//  next_move=4'b0010, start pulse cycle 0 -> dir[2]=0 from cycle 1, step[2] high cycles
//   3-4, 7-8, 11-12; move_done+busy-end at cycle 19; move_err=0.
//  next_move=4'b1101 -> dir[5]=1 from cycle 1, 3 pulses on step[5] only, done cycle 19.
//  next_move=4'b0111 -> move_done and move_err at cycle 1; step/dir unchanged.
//  start_move pulsed at cycles 5 and 19 during a move -> ignored; exactly one move_done.
//  reset_n low at cycle 8 (during STEP_HI) -> step=0 same cycle, no move_done;
//   new move after release completes normally in 19 cycles.

Source files
------------

// File: rtl/move_executor.sv
// Cube move executor: accepts one move from the sequencer, sets the direction of the
// selected face motor, emits a fixed train of step pulses, waits for the mechanics to
// settle, then pulses move_done. Only one motor is ever driven at a time.
module move_executor #(
  parameter int unsigned STEPS_PER_MOVE   = 50,
  parameter int unsigned STEP_HALF_CYCLES = 50000,
  parameter int unsigned DIR_SETUP_CYCLES = 1000,
  parameter int unsigned SETTLE_CYCLES    = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] next_move,
  input  logic       start_move,
  output logic       move_done,
  output logic       move_err,
  output logic       busy,
  output logic [5:0] step,
  output logic [5:0] dir
);

  // One shared cycle timer, wide enough for the longest timed phase.
  localparam int unsigned MaxSH  = (DIR_SETUP_CYCLES > STEP_HALF_CYCLES) ?
                                   DIR_SETUP_CYCLES : STEP_HALF_CYCLES;
  localparam int unsigned MaxAll = (MaxSH > SETTLE_CYCLES) ? MaxSH : SETTLE_CYCLES;
  localparam int unsigned TW     = (MaxAll < 1) ? 1 : $clog2(MaxAll + 1);
  localparam int unsigned PW     = (STEPS_PER_MOVE < 1) ? 1 : $clog2(STEPS_PER_MOVE + 1);

  // Terminal counts; a zero-length phase still occupies one cycle.
  localparam logic [TW-1:0] SetupLast  =
      TW'((DIR_SETUP_CYCLES == 0) ? 0 : DIR_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HalfLast   =
      TW'((STEP_HALF_CYCLES == 0) ? 0 : STEP_HALF_CYCLES - 1);
  localparam logic [TW-1:0] SettleLast =
      TW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PulsesLast =
      PW'((STEPS_PER_MOVE == 0) ? 0 : STEPS_PER_MOVE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStepHi,
    StStepLo,
    StSettle,
    StDone
  } state_e;

  state_e          state;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   pulses;
  logic [5:0]      face_oh;

  logic [5:0]      req_oh;
  logic            req_valid;

  // Decode the requested face into a motor select.
  always_comb begin
    req_valid = (next_move[2:0] < 3'd6);
    req_oh    = 6'b000001 << next_move[2:0];
  end

  // Move sequencer with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      timer     <= '0;
      pulses    <= '0;
      face_oh   <= '0;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      busy      <= 1'b0;
      step      <= '0;
      dir       <= '0;
    end else begin
      move_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_move) begin
            busy     <= 1'b1;
            timer    <= '0;
            pulses   <= '0;
            if (req_valid) begin
              face_oh  <= req_oh;
              move_err <= 1'b0;
              dir      <= next_move[3] ? (dir | req_oh) : (dir & ~req_oh);
              state    <= StSetup;
            end else begin
              // Bad face code: report immediately, never touch the motors.
              face_oh   <= '0;
              move_err  <= 1'b1;
              move_done <= 1'b1;
              state     <= StDone;
            end
          end
        end
        StSetup: begin
          if (timer == SetupLast) begin
            timer <= '0;
            step  <= face_oh;
            state <= StStepHi;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StStepHi: begin
          if (timer == HalfLast) begin
            timer <= '0;
            step  <= '0;
            state <= StStepLo;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StStepLo: begin
          if (timer == HalfLast) begin
            timer <= '0;
            if (pulses == PulsesLast) begin
              state <= StSettle;
            end else begin
              pulses <= pulses + PW'(1);
              step   <= face_oh;
              state  <= StStepHi;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StSettle: begin
          if (timer == SettleLast) begin
            timer     <= '0;
            move_done <= 1'b1;
            state     <= StDone;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          step  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_executor.sv
// Self-checking bench for move_executor with small timing parameters.
module tb_move_executor;

  localparam int STEPS  = 3;
  localparam int HALF   = 2;
  localparam int SETUP  = 2;
  localparam int SETTLE = 4;
  localparam int LAT    = 1 + SETUP + 2 * HALF * STEPS + SETTLE;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] next_move = '0;
  logic       start_move = 1'b0;
  logic       move_done;
  logic       move_err;
  logic       busy;
  logic [5:0] step;
  logic [5:0] dir;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state carried between moves.
  logic [5:0] m_dir = '0;
  logic       m_err = 1'b0;

  typedef struct {
    logic [3:0] nm;
    int         lat;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  move_executor #(
    .STEPS_PER_MOVE  (STEPS),
    .STEP_HALF_CYCLES(HALF),
    .DIR_SETUP_CYCLES(SETUP),
    .SETTLE_CYCLES   (SETTLE)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .next_move (next_move),
    .start_move(start_move),
    .move_done (move_done),
    .move_err  (move_err),
    .busy      (busy),
    .step      (step),
    .dir       (dir)
  );

  always #5 clock = ~clock;

  function automatic logic [14:0] outs();
    return {move_done, move_err, busy, step, dir};
  endfunction

  // Expected outputs k cycles after acceptance, from the move timing rules.
  function automatic logic [14:0] expect_at(input logic [3:0] nm, input int k,
                                            input logic [5:0] d0);
    logic [5:0] oh;
    logic [5:0] d;
    logic [5:0] s;
    int         rel;
    if (nm[2:0] > 3'd5) begin
      return {(k == 1), 1'b1, (k == 1), 6'b0, d0};
    end
    oh  = 6'b000001 << nm[2:0];
    d   = nm[3] ? (d0 | oh) : (d0 & ~oh);
    rel = k - 1 - SETUP;
    s   = (rel >= 0 && rel < 2 * HALF * STEPS && (rel % (2 * HALF)) < HALF) ? oh : 6'b0;
    return {(k == LAT), 1'b0, (k <= LAT), s, d};
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got done/err/busy/step/dir=%b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One move: start in cycle 0, extra start pulses in cycles flagged by 'extra',
  // optionally scramble next_move afterwards; check every cycle through lat+1.
  task automatic run_move(input string name, input logic [3:0] nm, input logic [31:0] extra,
                          input bit scramble, output int done_cyc);
    int lat;
    lat = (nm[2:0] > 3'd5) ? 1 : LAT;
    done_cyc = -1;
    @(posedge clock); #1;
    next_move  = nm;
    start_move = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clock); #1;
      start_move = (k <= lat) ? extra[k] : 1'b0;
      if (scramble) next_move = 4'($urandom_range(0, 15));
      @(negedge clock);
      if (move_done && done_cyc < 0) done_cyc = k;
      check(name, outs(), (k <= lat) ? expect_at(nm, k, m_dir)
                                     : {1'b0, expect_at(nm, lat, m_dir)[13], 1'b0, 6'b0,
                                        expect_at(nm, lat, m_dir)[5:0]});
    end
    if (nm[2:0] <= 3'd5) begin
      m_dir = nm[3] ? (m_dir | (6'b1 << nm[2:0])) : (m_dir & ~(6'b1 << nm[2:0]));
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    next_move = '0;
  endtask

  initial begin
    int dc;
    int dones[$];
    logic [3:0] nm;
    logic [31:0] ex;

    vecs.push_back('{nm: 4'b0010, lat: 19, err: 1'b0});
    vecs.push_back('{nm: 4'b1101, lat: 19, err: 1'b0});
    vecs.push_back('{nm: 4'b0111, lat: 1,  err: 1'b1});
    vecs.push_back('{nm: 4'b1000, lat: 19, err: 1'b0});
    vecs.push_back('{nm: 4'b1110, lat: 1,  err: 1'b1});
    vecs.push_back('{nm: 4'b0101, lat: 19, err: 1'b0});

    // Reset, then ten idle cycles with everything low.
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_after_reset", outs(), 15'b0);
    end

    // Table of directed moves.
    foreach (vecs[i]) begin
      run_move("table_move", vecs[i].nm, 32'b0, 1'b0, dc);
      check_int("table_latency", dc, vecs[i].lat);
      check_int("table_err_held", int'(move_err), int'(vecs[i].err));
    end

    // Start pulses during the move (cycle 5 and the DONE cycle) are ignored.
    run_move("ignored_starts", 4'b0011, (32'b1 << 5) | (32'b1 << 19), 1'b1, dc);
    check_int("ignored_starts_latency", dc, LAT);

    // Held start re-triggers on the first idle cycle after DONE.
    @(posedge clock); #1;
    next_move  = 4'b1100;
    start_move = 1'b1;
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      @(posedge clock); #1;
      if (k >= 2 * LAT + 1) start_move = 1'b0;
      @(negedge clock);
      if (move_done) dones.push_back(k);
    end
    check_int("held_start_count", dones.size(), 2);
    if (dones.size() == 2) begin
      check_int("held_start_first", dones[0], LAT);
      check_int("held_start_second", dones[1], 2 * LAT + 1);
    end
    m_dir = m_dir | 6'b010000;
    check("held_start_idle", outs(), {3'b000, 6'b0, m_dir});

    // Reset during STEP_HI drops step at once and suppresses move_done.
    @(posedge clock); #1;
    next_move  = 4'b0001;
    start_move = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      start_move = 1'b0;
    end
    @(negedge clock);
    check("pre_reset_step", outs(), expect_at(4'b0001, 8, m_dir));
    #2 reset_n = 1'b0;
    #1 check("reset_drops_step", outs(), 15'b0);
    m_dir = '0;
    m_err = 1'b0;
    dc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (move_done) dc++;
    end
    check_int("no_done_after_reset", dc, 0);
    #2 reset_n = 1'b1;
    run_move("after_reset", 4'b1001, 32'b0, 1'b0, dc);
    check_int("after_reset_latency", dc, LAT);

    // Randomized moves with stray starts and next_move noise.
    for (int r = 0; r < 25; r++) begin
      nm = 4'($urandom_range(0, 15));
      ex = $urandom() & $urandom() & 32'h000f_fffe;
      if (nm[2:0] > 3'd5) ex = ex & 32'h2;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      run_move("random_move", nm, ex, 1'b1, dc);
      check_int("random_latency", dc, (nm[2:0] > 3'd5) ? 1 : LAT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish before limit");
    $fatal(1, "timeout");
  end

endmodule
